// File: rtl/spi_rx_engine_if.sv
// Receive-side handshake bundle for spi_rx_engine: FIFO head data, valid/ready and fill level.
// The engine drives through the master modport and the consumer uses the slave modport.
interface spi_rx_engine_if #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] rx_data;
    logic              rx_vld;
    logic              rx_rdy;
    logic [LVL_W-1:0]  rx_level;

    modport master (
        output rx_data,
        output rx_vld,
        output rx_level,
        input  rx_rdy
    );

    modport slave (
        input  rx_data,
        input  rx_vld,
        input  rx_level,
        output rx_rdy
    );
endinterface

// File: rtl/spi_rx_engine.sv
// SPI receive datapath: samples sdi on the mode-selected SCLK strobe, assembles 1..DATA_W-bit frames
// and buffers them in a first-word fall-through FIFO drained over the valid/ready bundle.
module spi_rx_engine #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = $clog2(DATA_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_cpol_i,
    input  logic             cfg_cpha_i,
    input  logic             cfg_lsb_first_i,
    input  logic [LEN_W-1:0] cfg_frame_len_i,
    input  logic             cs_active_i,
    input  logic             sclk_rise_i,
    input  logic             sclk_fall_i,
    input  logic             sdi_i,
    input  logic             ovf_clr_i,
    spi_rx_engine_if.master  rx_if,
    output logic             rx_ovf_o,
    output logic             frame_abort_o,
    output logic             busy_o
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sr_q, sr_d, sr_shift;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              abort_q, abort_d;
    logic              act_cpol, act_cpha, act_lsb, sample;
    logic [LEN_W-1:0]  act_len, in_len;
    logic              push;
    logic [DATA_W-1:0] push_data;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              full, empty, pop, wr_en, ovf_set;

    assign in_len = (cfg_frame_len_i == '0 || cfg_frame_len_i > LEN_MAX) ? LEN_MAX : cfg_frame_len_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            len_q     <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            len_q     <= len_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            abort_q   <= abort_d;
        end
    end

    // In IDLE the live config applies so an edge coinciding with cs assertion is captured as bit 0.
    always_comb begin
        state_d   = state_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        len_d     = len_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = 1'b0;
        push      = 1'b0;
        push_data = '0;
        sample    = 1'b0;
        act_cpol  = cpol_q;
        act_cpha  = cpha_q;
        act_lsb   = lsb_q;
        act_len   = len_q;
        if (state_q == IDLE) begin
            act_cpol = cfg_cpol_i;
            act_cpha = cfg_cpha_i;
            act_lsb  = cfg_lsb_first_i;
            act_len  = in_len;
        end

        case (state_q)
            IDLE: begin
                if (cs_active_i) begin
                    state_d = SHIFT;
                    cpol_d  = cfg_cpol_i;
                    cpha_d  = cfg_cpha_i;
                    lsb_d   = cfg_lsb_first_i;
                    len_d   = in_len;
                    sample  = (act_cpol == act_cpha) ? sclk_rise_i : sclk_fall_i;
                end
            end
            SHIFT: begin
                if (!cs_active_i) begin
                    state_d   = IDLE;
                    abort_d   = (bit_cnt_q != '0);
                    sr_d      = '0;
                    bit_cnt_d = '0;
                end else begin
                    sample = (act_cpol == act_cpha) ? sclk_rise_i : sclk_fall_i;
                end
            end
            default: state_d = IDLE;
        endcase

        sr_shift = {sr_q[DATA_W-2:0], sdi_i};
        if (act_lsb) begin
            sr_shift = sr_q;
            sr_shift[bit_cnt_q[IDX_W-1:0]] = sdi_i;
        end

        if (sample) begin
            if (bit_cnt_q == act_len - LEN_ONE) begin
                push      = 1'b1;
                push_data = sr_shift;
                sr_d      = '0;
                bit_cnt_d = '0;
            end else begin
                sr_d      = sr_shift;
                bit_cnt_d = bit_cnt_q + LEN_ONE;
            end
        end
    end

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    assign pop     = !empty && rx_if.rx_rdy;
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    // Overflow set takes priority over a same-cycle clear request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rx_ovf_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (ovf_set)        rx_ovf_o <= 1'b1;
            else if (ovf_clr_i) rx_ovf_o <= 1'b0;
        end
    end

    assign rx_if.rx_data  = empty ? '0 : mem[rd_ptr];
    assign rx_if.rx_vld   = !empty;
    assign rx_if.rx_level = level;
    assign frame_abort_o  = abort_q;
    assign busy_o         = (state_q == SHIFT);
endmodule
